// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 Set-2 scan-code decoder.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    // Keyboard housekeeping bytes that never start a key event.
    function automatic logic is_filtered(input logic [7:0] b);
        return (b == PS2_ACK) || (b == PS2_BAT) || (b == PS2_ECHO) ||
               (b == PS2_RESEND) || (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead FIFO; the head output holds its last value while empty.
module ps2_event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] held;
    logic             pop_ok;
    logic             push_ok;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign head_data = empty ? held : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            held   <= '0;
        end else begin
            held <= head_data;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Resolves E0/F0 prefix sequences into key events, queues them and tracks the last make code.
//   state   | meaning
//   IDLE    | no prefix pending
//   EXT     | E0 seen
//   BRK     | F0 seen
//   EXT_BRK | E0 and F0 both seen
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [7:0]  out_code,
    output logic        out_brk,
    output logic        out_ext,
    output logic [15:0] last_code,
    output logic        overflow
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int NW = $clog2(FIFO_DEPTH) + 1;

    state_t     state;
    state_t     next_state;
    logic       decode_emit;
    logic       emit;
    ps2_event_t ev;
    ps2_event_t head;
    logic [CW-1:0] timer;
    logic       fifo_full;
    logic       fifo_empty;
    logic [NW-1:0] fifo_count;
    logic       pop;

    always_comb begin
        next_state  = state;
        decode_emit = 1'b0;
        ev          = '{ext: 1'b0, brk: 1'b0, code: in_data};
        case (state)
            IDLE: begin
                if (in_data == PS2_EXT)      next_state = EXT;
                else if (in_data == PS2_BRK) next_state = BRK;
                else if (!is_filtered(in_data)) decode_emit = 1'b1;
            end
            EXT: begin
                if (in_data == PS2_BRK) next_state = EXT_BRK;
                else if (in_data != PS2_EXT) begin
                    decode_emit = 1'b1;
                    ev.ext      = 1'b1;
                    next_state  = IDLE;
                end
            end
            BRK: begin
                if (in_data == PS2_EXT) next_state = EXT_BRK;
                else if (in_data != PS2_BRK) begin
                    decode_emit = 1'b1;
                    ev.brk      = 1'b1;
                    next_state  = IDLE;
                end
            end
            EXT_BRK: begin
                if (in_data != PS2_EXT && in_data != PS2_BRK) begin
                    decode_emit = 1'b1;
                    ev.ext      = 1'b1;
                    ev.brk      = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign emit      = in_valid && decode_emit;
    assign out_valid = (fifo_count != '0);
    assign pop       = !fifo_empty && out_ready;

    ps2_event_fifo #(
        .WIDTH ($bits(ps2_event_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (emit),
        .push_data (ev),
        .pop       (pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_code = head.code;
    assign out_brk  = head.brk;
    assign out_ext  = head.ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            last_code <= 16'h0000;
            overflow  <= 1'b0;
        end else begin
            // An arriving byte always wins over a timeout expiring in the same cycle.
            if (in_valid) begin
                state <= next_state;
                timer <= '0;
            end else if (state == IDLE) begin
                timer <= '0;
            end else if (timer == CW'(TIMEOUT_CYCLES - 1)) begin
                state <= IDLE;
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
            if (emit && !ev.brk) begin
                last_code <= {(ev.ext ? PS2_EXT : 8'h00), ev.code};
            end
            if (emit && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed plus randomized bench for ps2_scancode_decoder against a byte-level reference model.
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 4;
    localparam int TO    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_code;
    logic        out_brk;
    logic        out_ext;
    logic [15:0] last_code;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    // Reference model: pending-prefix flags, queue of events {ext,brk,code}.
    logic [9:0]  q[$];
    bit          pend, pext, pbrk;
    int          gap;
    logic [15:0] m_last;
    bit          m_ovf;
    logic [9:0]  m_held;

    always #5 clk = ~clk;

    ps2_scancode_decoder #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_code  (out_code),
        .out_brk   (out_brk),
        .out_ext   (out_ext),
        .last_code (last_code),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit filt(input logic [7:0] b);
        return b == 8'hFA || b == 8'hAA || b == 8'hEE || b == 8'hFE || b == 8'h00 || b == 8'hFF;
    endfunction

    task automatic model_edge(input bit r, input bit v, input logic [7:0] b, input bit rdy);
        bit         do_pop;
        bit         emit;
        logic [9:0] ev;
        if (r) begin
            q.delete();
            pend = 0; pext = 0; pbrk = 0; gap = 0;
            m_last = 16'h0000; m_ovf = 0; m_held = 10'h000;
            return;
        end
        if (q.size() > 0) m_held = q[0];
        do_pop = (q.size() > 0) && rdy;
        emit   = 0;
        ev     = 10'h000;
        if (v) begin
            gap = 0;
            if (!pend) begin
                if (b == 8'hE0) begin pend = 1; pext = 1; end
                else if (b == 8'hF0) begin pend = 1; pbrk = 1; end
                else if (!filt(b)) begin emit = 1; ev = {2'b00, b}; end
            end else begin
                if (b == 8'hE0) pext = 1;
                else if (b == 8'hF0) pbrk = 1;
                else begin
                    emit = 1; ev = {pext, pbrk, b};
                    pend = 0; pext = 0; pbrk = 0;
                end
            end
        end else if (pend) begin
            gap++;
            if (gap >= TO) begin pend = 0; pext = 0; pbrk = 0; gap = 0; end
        end
        if (do_pop) void'(q.pop_front());
        if (emit) begin
            if (q.size() < DEPTH) q.push_back(ev);
            else m_ovf = 1;
            if (!ev[8]) m_last = {(ev[9] ? 8'hE0 : 8'h00), b};
        end
    endtask

    task automatic compare_all();
        logic [9:0] h;
        h = (q.size() > 0) ? q[0] : m_held;
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("out_code",  32'(out_code),  32'(h[7:0]));
        chk("out_brk",   32'(out_brk),   32'(h[8]));
        chk("out_ext",   32'(out_ext),   32'(h[9]));
        chk("last_code", 32'(last_code), 32'(m_last));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        chk("occupancy", 32'(u_dut.fifo_count), 32'(q.size()));
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] b, input bit rdy);
        rst = r; in_valid = v; in_data = b; out_ready = rdy;
        @(posedge clk);
        model_edge(r, v, b, rdy);
        #1;
        compare_all();
    endtask

    task automatic send(input logic [7:0] b, input bit rdy);
        step(0, 1, b, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, rdy);
    endtask

    initial begin
        logic [7:0] pool [10];
        logic [7:0] b;
        pool = '{8'hE0, 8'hF0, 8'hFA, 8'hAA, 8'h00, 8'hFF, 8'h1C, 8'h75, 8'hEE, 8'hFE};
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_last_code", 32'(last_code), 32'h0);
        chk("rst_overflow",  32'(overflow),  32'h0);

        // Make then break of 1C
        send(8'h1C, 1);
        chk("make_1c_code", 32'(out_code), 32'h1C);
        send(8'hF0, 1);
        chk("make_1c_one_cycle", 32'(out_valid), 32'h0);
        send(8'h1C, 1);
        chk("brk_1c", 32'({out_valid, out_ext, out_brk, out_code}), 32'h51C);
        chk("brk_1c_last", 32'(last_code), 32'h001C);
        idle(1, 1);

        // Extended make and break of 75
        send(8'hE0, 1); send(8'h75, 1);
        chk("ext_make_last", 32'(last_code), 32'hE075);
        send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 1);
        chk("ext_brk_75", 32'({out_ext, out_brk, out_code}), 32'h375);
        chk("ext_brk_last", 32'(last_code), 32'hE075);
        idle(1, 1);

        // Filtered bytes in IDLE, but not after a prefix
        send(8'hFA, 1); send(8'hAA, 1); send(8'h00, 1); send(8'hFF, 1);
        chk("filter_no_event", 32'(out_valid), 32'h0);
        chk("filter_last", 32'(last_code), 32'hE075);
        send(8'hE0, 1); send(8'hFA, 1);
        chk("ext_fa", 32'({out_valid, out_ext, out_brk, out_code}), 32'h6FA);
        idle(1, 1);

        // Overflow and full-with-pop push
        for (int i = 1; i <= 6; i++) send(8'(i), 0);
        chk("ovf_set", 32'(overflow), 32'h1);
        chk("ovf_last", 32'(last_code), 32'h0006);
        chk("ovf_head", 32'(out_code), 32'h01);
        send(8'h07, 1);
        chk("full_pop_push_occ", 32'(u_dut.fifo_count), 32'h4);
        chk("full_pop_push_head", 32'(out_code), 32'h02);
        idle(4, 1);
        chk("drain_empty", 32'(out_valid), 32'h0);
        chk("drain_ovf_sticky", 32'(overflow), 32'h1);

        // Timeout boundary: 15 idle cycles keeps the prefix, 16 drops it
        send(8'hE0, 1); idle(TO - 1, 1); send(8'h75, 1);
        chk("prefix_kept", 32'({out_ext, out_code}), 32'h175);
        idle(1, 1);
        send(8'hE0, 1); idle(TO, 1); send(8'h1C, 1);
        chk("prefix_timeout", 32'({out_valid, out_ext, out_code}), 32'h21C);
        idle(1, 1);

        // Reset mid-sequence discards a pending F0
        send(8'hF0, 1);
        step(1, 0, 8'h00, 1);
        send(8'h1C, 1);
        chk("rst_mid_brk", 32'({out_valid, out_brk, out_code}), 32'h21C);
        chk("rst_mid_ovf", 32'(overflow), 32'h0);

        // Randomized bursts with idle gaps that straddle the timeout
        for (int burst = 0; burst < 300; burst++) begin
            int len;
            len = int'($urandom_range(1, 8));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 9) < 7) b = pool[$urandom_range(0, 9)];
                else b = 8'($urandom_range(0, 255));
                step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), b,
                     ($urandom_range(0, 2) != 0));
            end
            idle(int'($urandom_range(0, 20)), ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Downstream stage of the PS/2 byte receiver. Consumes raw scan-code bytes (one-cycle strobe per byte) and resolves Set-2 prefix sequences (E0 extended, F0 break) into key events {ext, brk, code}.
- Buffers events in a small show-ahead FIFO with a ready/valid output.
- Maintains a 16-bit last-make-code register for the 4-digit hex display path.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries (power of two, ≥2).
- TIMEOUT_CYCLES, 500000, clk cycles a prefix may remain pending without a following byte (10 ms at 50 MHz).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  scan-code byte from receiver.
- in_valid  in  1  one-cycle strobe; in_data valid this cycle.
- out_ready  in  1  consumer accepts head event this cycle.
- out_valid  out  1  FIFO non-empty.
- out_code  out  8  head event code byte.
- out_brk  out  1  head event is a key release.
- out_ext  out  1  head event was E0-prefixed.
- last_code  out  16  {8'hE0 or 8'h00, code} of most recent make event.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, timeout counter=0, FIFO empty, out_valid=0, out_code=0, out_brk=0, out_ext=0, last_code=16'h0000, overflow=0. Reset mid-sequence discards any pending prefix; no event is emitted.
- Decoder FSM, evaluated only on in_valid:
  - IDLE: E0→EXT; F0→BRK; FA/AA/EE/FE (ack/BAT/echo/resend)→dropped, stay IDLE; 00/FF→dropped, stay IDLE; anything else→emit {0,0,code}.
  - EXT: F0→EXT_BRK; E0→stay EXT; other→emit {1,0,code}, →IDLE.
  - BRK: E0→EXT_BRK; F0→stay BRK; other→emit {0,1,code}, →IDLE.
  - EXT_BRK: E0/F0→stay; other→emit {1,1,code}, →IDLE.
  - The filter list applies in IDLE only. Any non-prefix byte in a prefix state is emitted.
- Timeout: the counter clears on every in_valid and while in IDLE. Otherwise it increments. When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE next cycle with no event. If in_valid arrives in the same cycle, the byte takes precedence and the timeout is ignored.
- Emit: the event is written to the FIFO at the posedge that samples in_valid. If the FIFO was empty, out_valid=1 and out_* show the event from the next cycle (1-cycle latency).
- FIFO: show-ahead; out_* always reflect the head entry. A pop occurs when out_valid&&out_ready. out_* hold their last values when empty.
  - A push is accepted if not full, or if full with a pop in the same cycle.
  - A push is accepted into an empty FIFO even when out_ready=1; it is not popped that cycle.
  - If full and no pop, the event is dropped and overflow is set until rst.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full/empty are resolved by an occupancy counter of width log2(FIFO_DEPTH)+1.
- last_code: updated on every emitted make event (brk=0), including a dropped one. It holds on break events.
- in_valid pulses closer than one cycle apart are impossible by construction. Back-to-back cycles must be handled.

Decomposition:
- Package ps2_pkg holds:
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_ACK=8'hFA, PS2_BAT=8'hAA, PS2_ECHO=8'hEE, PS2_RESEND=8'hFE, PS2_ERR0=8'h00, PS2_ERR1=8'hFF;
  - decoder state enum (IDLE, EXT, BRK, EXT_BRK);
  - packed event type {ext, brk, code[7:0]} (10 bits).
- One sub-module, ps2_event_fifo: parameterised width/depth, show-ahead, push/pop/full/empty/count. The decoder FSM, timeout and last_code stay in the top.

Test Plan:
- After rst, bytes 1C then F0,1C with out_ready=1 → event {0,0,1C} then {0,1,1C}; last_code=001C; out_valid is high for exactly one cycle per event.
- E0,75 then E0,F0,75 → events {1,0,75}, {1,1,75}; last_code=E075 after the first event and unchanged after the second.
- FA, AA, 00, FF in IDLE → no events; out_valid stays 0; last_code unchanged. Then E0,FA → event {1,0,FA}.
- out_ready=0, send 6 make codes 01..06 (FIFO_DEPTH=4) → four entries 01..04 buffered, overflow=1, last_code=0006. Raising out_ready drains 01,02,03,04 in order, one per cycle, and overflow stays 1.
- With FIFO full and out_ready=1, push code 07 in the same cycle as a pop → 07 accepted; occupancy stays 4; overflow unchanged.
- With TIMEOUT_CYCLES=16: send E0, wait 16 idle cycles, send 1C → event {0,0,1C}. Separately, send F0 then assert rst for 1 cycle, then 1C → event {0,0,1C}, overflow=0.
